// File: rtl/pixel_write_buffer_if.sv
// Pixel write buffer bus: sprite-drawer side pixel stream, flush control,
// VGA-adapter side registered write port and buffer status.
interface pixel_write_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          plot;
  logic [8:0]    xCoord;
  logic [7:0]    yCoord;
  logic [2:0]    color;
  logic          flush;
  logic          vga_ready;
  logic          vga_plot;
  logic [8:0]    vga_x;
  logic [7:0]    vga_y;
  logic [2:0]    vga_color;
  logic          in_ready;
  logic [CW-1:0] count;
  logic          overflow;

  // Producer / consumer environment that drives the buffer.
  modport master (
    output plot, xCoord, yCoord, color, flush, vga_ready,
    input  vga_plot, vga_x, vga_y, vga_color, in_ready, count, overflow
  );

  // The buffer itself.
  modport slave (
    input  plot, xCoord, yCoord, color, flush, vga_ready,
    output vga_plot, vga_x, vga_y, vga_color, in_ready, count, overflow
  );
endinterface

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: circular FIFO decoupling the sprite drawer from the
// VGA adapter write port. Entries are {x[8:0], y[7:0], color[2:0]}.
// The head entry is loaded into registered VGA outputs one cycle after it
// is popped; there is no push-to-output bypass, so an empty FIFO needs two
// edges from push to vga_plot.
// Optional build macro PIXEL_CLIP_EN: drop pixels outside 320x240 at the
// input (not stored, no count change, no overflow).
module pixel_write_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  pixel_write_buffer_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // Storage (not reset) and registered state.
  logic [19:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          vga_plot_q, vga_plot_d;
  logic [8:0]    vga_x_q, vga_x_d;
  logic [7:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_color_q, vga_color_d;
  logic          overflow_q, overflow_d;

  logic          accept_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic [19:0]   head_s;

  // Input qualification: which strobed pixels are candidates for storage.
  always_comb begin
    accept_s = 1'b0;
`ifdef PIXEL_CLIP_EN
    if (bus.plot && (bus.xCoord < 9'd320) && (bus.yCoord < 8'd240)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
`else
    accept_s = bus.plot;
`endif
  end

  assign full_s = (count_q == CW'(DEPTH));
  assign push_s = accept_s && !full_s && !bus.flush;
  assign pop_s  = bus.vga_ready && (count_q != {CW{1'b0}}) && !bus.flush;
  assign head_s = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy, VGA output registers and overflow.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    vga_plot_d  = 1'b0;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    overflow_d  = overflow_q;
    if (bus.flush) begin
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
      vga_plot_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        vga_plot_d  = 1'b1;
        vga_x_d     = head_s[19:11];
        vga_y_d     = head_s[10:3];
        vga_color_d = head_s[2:0];
      end else begin
        rd_ptr_d   = rd_ptr_q;
        vga_plot_d = 1'b0;
      end
      // A full-FIFO strobe is dropped even when a pop frees a slot this cycle.
      if (accept_s && full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      vga_plot_q  <= 1'b0;
      vga_x_q     <= 9'd0;
      vga_y_q     <= 8'd0;
      vga_color_q <= 3'd0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      vga_plot_q  <= vga_plot_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      overflow_q  <= overflow_d;
    end
  end

  // Pixel storage write; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {bus.xCoord, bus.yCoord, bus.color};
    end
  end

  assign bus.vga_plot  = vga_plot_q;
  assign bus.vga_x     = vga_x_q;
  assign bus.vga_y     = vga_y_q;
  assign bus.vga_color = vga_color_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.in_ready  = (count_q < CW'(DEPTH));

endmodule
